// File: rtl/tohost_monitor_if.sv
// Result bus between tohost_monitor (master) and the top level / bench (slave).
interface tohost_monitor_if #(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_W     = 32
);
    localparam int unsigned HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic [NUM_HARTS*XLEN-1:0] tohost;
    logic                      core_rst_n;
    logic [NUM_HARTS-1:0]      hart_done;
    logic [NUM_HARTS-1:0]      hart_fail;
    logic                      done;
    logic                      pass;
    logic                      fail;
    logic                      timeout;
    logic [HART_W-1:0]         fail_hart;
    logic [XLEN-2:0]           fail_code;
    logic [CNT_W-1:0]          cycle_count;

    modport master (
        input  tohost,
        output core_rst_n, hart_done, hart_fail, done, pass, fail, timeout,
               fail_hart, fail_code, cycle_count
    );

    modport slave (
        output tohost,
        input  core_rst_n, hart_done, hart_fail, done, pass, fail, timeout,
               fail_hart, fail_code, cycle_count
    );
endinterface

// File: rtl/tohost_monitor.sv
// Run controller: holds the core in reset, then watches per-hart tohost words for pass/fail/timeout.
// Build option: define TOHOST_MONITOR_TIMEOUT_EN to enable the run-cycle timeout.
module tohost_monitor #(
    parameter int unsigned NUM_HARTS      = 1,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned RST_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 262144,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    tohost_monitor_if.master bus
);
    localparam int unsigned HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                          state_q;
    logic [HOLD_W-1:0]               hold_cnt_q;
    logic                            core_rst_n_q;
    logic [CNT_W-1:0]                cycle_count_q;
    logic [NUM_HARTS-1:0]            hart_done_q;
    logic [NUM_HARTS-1:0]            hart_fail_q;
    logic [NUM_HARTS-1:0][XLEN-1:0]  latch_q;
    logic                            done_q;
    logic                            pass_q;
    logic                            fail_q;
    logic                            timeout_q;
    logic [HART_W-1:0]               fail_hart_q;
    logic [XLEN-2:0]                 fail_code_q;

    logic [NUM_HARTS-1:0]            hart_done_d;
    logic [NUM_HARTS-1:0]            hart_fail_d;
    logic [NUM_HARTS-1:0][XLEN-1:0]  latch_d;
    logic [HART_W-1:0]               fail_hart_d;
    logic [XLEN-2:0]                 fail_code_d;
    logic                            fail_seen_c;
    logic                            all_done_c;
    logic                            any_fail_c;
    logic                            timeout_hit_c;

    // Latch first nonzero tohost per hart and pick the lowest-index failure.
    always_comb begin
        hart_done_d = hart_done_q;
        hart_fail_d = hart_fail_q;
        latch_d     = latch_q;
        fail_hart_d = '0;
        fail_code_d = '0;
        fail_seen_c = 1'b0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (!hart_done_q[i] && (bus.tohost[i*XLEN +: XLEN] != '0)) begin
                hart_done_d[i] = 1'b1;
                hart_fail_d[i] = (bus.tohost[i*XLEN +: XLEN] != XLEN'(1));
                latch_d[i]     = bus.tohost[i*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (hart_fail_d[i] && !fail_seen_c) begin
                fail_seen_c = 1'b1;
                fail_hart_d = HART_W'(i);
                fail_code_d = latch_d[i][XLEN-1:1];
            end
        end
    end

    assign all_done_c = &hart_done_d;
    assign any_fail_c = |hart_fail_d;

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    // Timeout only counts when nothing else completes on the same edge.
    assign timeout_hit_c = !(all_done_c || any_fail_c)
                         && (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Constant-false: the timeout path is absent from this build.
    assign timeout_hit_c = 1'b0 && (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            core_rst_n_q  <= 1'b0;
            cycle_count_q <= '0;
            hart_done_q   <= '0;
            hart_fail_q   <= '0;
            latch_q       <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_hart_q   <= '0;
            fail_code_q   <= '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                        state_q      <= S_RUN;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    hart_done_q <= hart_done_d;
                    hart_fail_q <= hart_fail_d;
                    latch_q     <= latch_d;
                    if (all_done_c || any_fail_c || timeout_hit_c) begin
                        state_q      <= S_DONE;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                        pass_q       <= all_done_c && !any_fail_c;
                        fail_q       <= any_fail_c || timeout_hit_c;
                        timeout_q    <= timeout_hit_c;
                        fail_hart_q  <= fail_hart_d;
                        fail_code_q  <= fail_code_d;
                    end else if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.hart_done   = hart_done_q;
    assign bus.hart_fail   = hart_fail_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.fail_hart   = fail_hart_q;
    assign bus.fail_code   = fail_code_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed and random per-hart write schedules against a schedule-level model.
module tb_tohost_monitor;
    localparam int unsigned NH      = 4;
    localparam int unsigned XL      = 32;
    localparam int unsigned RST_CYC = 4;
    localparam int unsigned TO_CYC  = 16;
    localparam int unsigned CW      = 32;
    localparam int          NEVER   = 1000000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    int          sch_w [NH];
    logic [31:0] sch_v [NH];

    tohost_monitor_if #(.NUM_HARTS(NH), .XLEN(XL), .CNT_W(CW)) bus ();

    tohost_monitor #(
        .NUM_HARTS(NH), .XLEN(XL), .RST_CYCLES(RST_CYC),
        .TIMEOUT_CYCLES(TO_CYC), .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reset for 3 cycles with garbage on tohost, then walk through the hold phase into RUN cycle 0.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.tohost = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check({tag, ":rst_rstn"}, bus.core_rst_n, 0);
        check({tag, ":rst_flags"}, {bus.done, bus.pass, bus.fail, bus.timeout}, 0);
        check({tag, ":rst_harts"}, {bus.hart_done, bus.hart_fail}, 0);
        check({tag, ":rst_fail_info"}, {bus.fail_hart, bus.fail_code}, 0);
        check({tag, ":rst_count"}, bus.cycle_count, 0);
        RST = 1'b0;
        for (int k = 1; k <= RST_CYC; k++) begin
            bus.tohost = {$urandom | 32'd1, $urandom, $urandom, $urandom};
            step();
            check({tag, ":hold_rstn"}, bus.core_rst_n, (k == RST_CYC) ? 64'd1 : 64'd0);
            check({tag, ":hold_count"}, bus.cycle_count, 0);
            check({tag, ":hold_done"}, {bus.done, bus.hart_done}, 0);
        end
    endtask

    // Drive the schedule in sch_w/sch_v (write cycle, -1 = never) and compare against the model.
    task automatic run_sched(input string tag, input bit rand_junk, input int max_c);
        int             end_c;
        int             last;
        int             fh;
        int             lim;
        bit             to;
        bit             all_w;
        logic [NH-1:0]  dmask;
        logic [NH-1:0]  fmask;
        logic [NH-1:0]  run_mask;
        logic [XL-2:0]  fc;

        end_c = NEVER; last = 0; to = 1'b0; all_w = 1'b1;
        for (int i = 0; i < NH; i++) begin
            if (sch_w[i] < 0) all_w = 1'b0;
            else begin
                if (sch_w[i] > last) last = sch_w[i];
                if (sch_v[i] != 32'd1 && sch_w[i] < end_c) end_c = sch_w[i];
            end
        end
        if (all_w && last < end_c) end_c = last;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
        if (end_c > int'(TO_CYC) - 1) begin
            end_c = int'(TO_CYC) - 1;
            to    = 1'b1;
        end
`endif
        dmask = '0; fmask = '0; fh = 0; fc = '0;
        for (int i = NH - 1; i >= 0; i--) begin
            if (sch_w[i] >= 0 && sch_w[i] <= end_c) begin
                dmask[i] = 1'b1;
                if (sch_v[i] != 32'd1) begin
                    fmask[i] = 1'b1;
                    fh = i;
                    fc = sch_v[i][31:1];
                end
            end
        end

        lim = (end_c < max_c) ? end_c : max_c;
        for (int c = 0; c <= lim; c++) begin
            for (int i = 0; i < NH; i++) begin
                if (sch_w[i] < 0 || c < sch_w[i]) bus.tohost[i*XL +: XL] = '0;
                else if (c == sch_w[i])           bus.tohost[i*XL +: XL] = sch_v[i];
                else                              bus.tohost[i*XL +: XL] = rand_junk ? $urandom : 32'd3;
            end
            step();
            if (c < end_c) begin
                run_mask = '0;
                for (int i = 0; i < NH; i++)
                    if (sch_w[i] >= 0 && sch_w[i] <= c) run_mask[i] = 1'b1;
                check({tag, ":run_done"}, {bus.done, bus.timeout}, 0);
                check({tag, ":run_rstn"}, bus.core_rst_n, 1);
                check({tag, ":run_count"}, bus.cycle_count, 64'(c + 1));
                check({tag, ":run_hart_done"}, bus.hart_done, run_mask);
                check({tag, ":run_hart_fail"}, bus.hart_fail, 0);
            end else begin
                check({tag, ":end_done"}, bus.done, 1);
                check({tag, ":end_rstn"}, bus.core_rst_n, 0);
                check({tag, ":end_pass"}, bus.pass, (!to && fmask == '0) ? 64'd1 : 64'd0);
                check({tag, ":end_fail"}, bus.fail, (to || fmask != '0) ? 64'd1 : 64'd0);
                check({tag, ":end_timeout"}, bus.timeout, 64'(to));
                check({tag, ":end_hart_done"}, bus.hart_done, dmask);
                check({tag, ":end_hart_fail"}, bus.hart_fail, fmask);
                check({tag, ":end_fail_hart"}, bus.fail_hart, 64'(fh));
                check({tag, ":end_fail_code"}, bus.fail_code, fc);
                check({tag, ":end_count"}, bus.cycle_count, 64'(end_c));
            end
        end
        if (lim == end_c) begin
            for (int k = 0; k < 3; k++) begin
                bus.tohost = {$urandom, $urandom, $urandom, $urandom};
                step();
                check({tag, ":frz_done"}, {bus.done, bus.core_rst_n}, 64'b10);
                check({tag, ":frz_count"}, bus.cycle_count, 64'(end_c));
                check({tag, ":frz_harts"}, {bus.hart_done, bus.hart_fail}, {dmask, fmask});
                check({tag, ":frz_code"}, {bus.fail_hart, bus.fail_code}, {2'(fh), fc});
            end
        end
    endtask

    initial begin
        bus.tohost = '0;

        do_reset("pass_same");
        sch_w = '{10, 10, 10, 10};
        sch_v = '{32'd1, 32'd1, 32'd1, 32'd1};
        run_sched("pass_same", 1'b1, 200);

        do_reset("pass_stagger");
        sch_w = '{3, 7, 1, 12};
        sch_v = '{32'd1, 32'd1, 32'd1, 32'd1};
        run_sched("pass_stagger", 1'b1, 200);

        do_reset("multi_fail");
        sch_w = '{-1, 5, 8, 8};
        sch_v = '{32'd0, 32'd1, 32'h9, 32'h15};
        run_sched("multi_fail", 1'b1, 200);

        do_reset("timeout");
        sch_w = '{-1, -1, -1, -1};
        sch_v = '{32'd0, 32'd0, 32'd0, 32'd0};
        run_sched("timeout", 1'b1, 100);

        do_reset("tie_break");
        sch_w = '{3, 3, 3, 15};
        sch_v = '{32'd1, 32'd1, 32'd1, 32'd1};
        run_sched("tie_break", 1'b1, 200);

        do_reset("sticky");
        sch_w = '{2, -1, -1, -1};
        sch_v = '{32'd1, 32'd0, 32'd0, 32'd0};
        run_sched("sticky", 1'b0, 12);

        // Reset pulsed mid-run with a hart already latched.
        do_reset("midrun");
        sch_w = '{2, 4, -1, -1};
        sch_v = '{32'd1, 32'd1, 32'd0, 32'd0};
        run_sched("midrun", 1'b1, 6);
        check("midrun:pre_rst", bus.hart_done, 4'b0011);
        do_reset("midrun_rst");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NH; i++) begin
                sch_w[i] = int'($urandom_range(0, 21)) - 1;
                if ($urandom_range(0, 2) != 0) sch_v[i] = 32'd1;
                else begin
                    sch_v[i] = $urandom;
                    if (sch_v[i] <= 32'd1) sch_v[i] = 32'h2A;
                end
            end
            do_reset("rand");
            run_sched("rand", 1'b1, 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
